// File: rtl/mii_tx_fifo_ser_if.sv
// Byte-side write handshake of the MII/RMII transmit serializer.
// The frame transmitter is the master, the serializer is the slave.
interface mii_tx_fifo_ser_if;
  logic       txen_i;
  logic       eof_i;
  logic [7:0] dat_i;
  logic       rdy_o;

  modport master (
    output txen_i, eof_i, dat_i,
    input  rdy_o
  );

  modport slave (
    input  txen_i, eof_i, dat_i,
    output rdy_o
  );
endinterface

// File: rtl/mii_tx_fifo_ser.sv
// MII/RMII transmit FIFO and LS-first symbol serializer with
// start threshold, underrun TX_ER, overflow drop and IFG timing.
module mii_tx_fifo_ser #(
  parameter int DEPTH_LOG2 = 2,
  parameter int OW         = 4,
  parameter int START_TH   = 2,
  parameter int IFG_CYC    = 24
) (
  input  logic                  txclk_i,
  input  logic                  rst,
  mii_tx_fifo_ser_if.slave      wr,
  output logic [OW-1:0]         dat_o,
  output logic                  txen_o,
  output logic                  txerr_o,
  output logic                  ovf_o,
  output logic                  unf_o,
  input  logic                  err_clr_i,
  output logic [DEPTH_LOG2:0]   lvl_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int NSL   = 8 / OW;
  localparam int GW    = $clog2(IFG_CYC + 1);
  localparam logic [1:0] LAST = 2'(NSL - 1);

  typedef enum logic [1:0] {IDLE, SEND, UNDER, GAP} st_t;

  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] waddr, raddr;
  logic [LW-1:0]         ecnt;
  logic [1:0]            sidx, sidx_n;
  logic [GW-1:0]         gcnt, gcnt_n;
  logic                  lst_eof, lst_eof_n;
  st_t                   st, st_n;
  logic [OW-1:0]         dat_n;
  logic                  txen_n, txerr_n;
  logic                  pop, wr_en, ovf_set, unf_set;
  logic [8:0]            head;

  function automatic logic [OW-1:0] slc(input logic [7:0] b,
                                        input logic [1:0] i);
    return b[int'(i)*OW +: OW];
  endfunction

  assign wr.rdy_o = (lvl_o != LW'(DEPTH));
  assign wr_en    = wr.txen_i & wr.rdy_o;
  assign ovf_set  = wr.txen_i & ~wr.rdy_o;
  assign head     = mem[raddr];

  // FIFO storage: tag each byte with its end-of-frame bit
  always_ff @(posedge txclk_i) begin
    if (wr_en) mem[waddr] <= {wr.eof_i, wr.dat_i};
  end

  // Read-side FSM: next state, registered symbol outputs and pop
  always_comb begin
    st_n      = st;
    sidx_n    = sidx;
    gcnt_n    = gcnt;
    lst_eof_n = lst_eof;
    dat_n     = dat_o;
    txen_n    = txen_o;
    txerr_n   = txerr_o;
    pop       = 1'b0;
    unf_set   = 1'b0;
    unique case (st)
      IDLE: begin
        dat_n   = '0;
        txen_n  = 1'b0;
        txerr_n = 1'b0;
        if (lvl_o >= LW'(START_TH) || ecnt != '0) begin
          st_n   = SEND;
          sidx_n = 2'd0;
          dat_n  = slc(head[7:0], 2'd0);
          txen_n = 1'b1;
        end
      end
      SEND: begin
        if (sidx != LAST) begin
          sidx_n = sidx + 2'd1;
          dat_n  = slc(head[7:0], sidx_n);
          if (sidx_n == LAST) begin
            pop       = 1'b1;
            lst_eof_n = head[8];
          end
        end else if (lst_eof) begin
          st_n   = GAP;
          txen_n = 1'b0;
          dat_n  = '0;
          gcnt_n = GW'(IFG_CYC - 1);
        end else if (lvl_o == '0) begin
          st_n    = UNDER;
          txen_n  = 1'b1;
          txerr_n = 1'b1;
          dat_n   = '0;
          unf_set = 1'b1;
        end else begin
          sidx_n = 2'd0;
          dat_n  = slc(head[7:0], 2'd0);
        end
      end
      UNDER: begin
        txen_n  = 1'b1;
        txerr_n = 1'b1;
        dat_n   = '0;
        if (lvl_o != '0) begin
          pop = 1'b1;
          if (head[8]) begin
            st_n    = GAP;
            txen_n  = 1'b0;
            txerr_n = 1'b0;
            gcnt_n  = GW'(IFG_CYC - 1);
          end
        end
      end
      GAP: begin
        txen_n  = 1'b0;
        txerr_n = 1'b0;
        dat_n   = '0;
        if (gcnt == '0) st_n = IDLE;
        else gcnt_n = gcnt - GW'(1);
      end
      default: st_n = IDLE;
    endcase
  end

  // State, pointers, occupancy and sticky status registers
  always_ff @(posedge txclk_i or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      waddr   <= '0;
      raddr   <= '0;
      lvl_o   <= '0;
      ecnt    <= '0;
      sidx    <= '0;
      gcnt    <= '0;
      lst_eof <= 1'b0;
      dat_o   <= '0;
      txen_o  <= 1'b0;
      txerr_o <= 1'b0;
      ovf_o   <= 1'b0;
      unf_o   <= 1'b0;
    end else begin
      st      <= st_n;
      sidx    <= sidx_n;
      gcnt    <= gcnt_n;
      lst_eof <= lst_eof_n;
      dat_o   <= dat_n;
      txen_o  <= txen_n;
      txerr_o <= txerr_n;
      if (wr_en) waddr <= waddr + DEPTH_LOG2'(1);
      if (pop)   raddr <= raddr + DEPTH_LOG2'(1);
      lvl_o <= lvl_o + LW'(wr_en) - LW'(pop);
      ecnt  <= ecnt + LW'(wr_en & wr.eof_i) - LW'(pop & head[8]);
      ovf_o <= ovf_set | (ovf_o & ~err_clr_i);
      unf_o <= unf_set | (unf_o & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_mii_tx_fifo_ser.sv
// Directed bench for mii_tx_fifo_ser: an MII (OW=4, START_TH=2) and
// an RMII (OW=2, START_TH=1) instance share one stimulus stream.
module tb_mii_tx_fifo_ser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txen = 1'b0, eof = 1'b0, err_clr = 1'b0;
  logic [7:0] dat = 8'h00;

  logic [3:0] dat_a;
  logic       txen_a, txerr_a, ovf_a, unf_a;
  logic [2:0] lvl_a;
  logic [1:0] dat_b;
  logic       txen_b, txerr_b, ovf_b, unf_b;
  logic [2:0] lvl_b;

  int n_chk = 0;
  int n_err = 0;

  mii_tx_fifo_ser_if ia ();
  mii_tx_fifo_ser_if ib ();

  assign ia.txen_i = txen;
  assign ia.eof_i  = eof;
  assign ia.dat_i  = dat;
  assign ib.txen_i = txen;
  assign ib.eof_i  = eof;
  assign ib.dat_i  = dat;

  mii_tx_fifo_ser #(.DEPTH_LOG2(2), .OW(4), .START_TH(2), .IFG_CYC(24)) dut_a (
    .txclk_i(clk), .rst(rst), .wr(ia), .dat_o(dat_a), .txen_o(txen_a),
    .txerr_o(txerr_a), .ovf_o(ovf_a), .unf_o(unf_a), .err_clr_i(err_clr),
    .lvl_o(lvl_a)
  );

  mii_tx_fifo_ser #(.DEPTH_LOG2(2), .OW(2), .START_TH(1), .IFG_CYC(24)) dut_b (
    .txclk_i(clk), .rst(rst), .wr(ib), .dat_o(dat_b), .txen_o(txen_b),
    .txerr_o(txerr_b), .ovf_o(ovf_b), .unf_o(unf_b), .err_clr_i(err_clr),
    .lvl_o(lvl_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       t;
    logic       e;
    logic [7:0] d;
    logic       xt;
    logic       xe;
    logic [3:0] xd;
    logic [2:0] xl;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic e, input logic [7:0] d);
    txen = t;
    eof  = e;
    dat  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    txen = 1'b0;
    eof = 1'b0;
    dat = 8'h00;
    err_clr = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    logic [1:0] rm [4];
    logic [1:0] ur [4];
    logic [3:0] b2 [4];

    tv[0]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 4'h0, 3'd1};
    tv[1]  = '{1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 4'h0, 3'd2};
    tv[2]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 4'h5, 3'd3};
    tv[3]  = '{1'b1, 1'b1, 8'hAB, 1'b1, 1'b0, 4'h5, 3'd3};
    tv[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h5, 3'd3};
    tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'hD, 3'd2};
    tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h2, 3'd2};
    tv[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h1, 3'd1};
    tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'hB, 3'd1};
    tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'hA, 3'd0};
    tv[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 3'd0};
    rm = '{2'd3, 2'd2, 2'd1, 2'd0};
    ur = '{2'd1, 2'd1, 2'd2, 2'd2};
    b2 = '{4'h3, 4'h4, 4'h5, 4'h6};

    // reset state, sampled while reset is held
    #2;
    chk("rst_txen", txen_a, 0);
    chk("rst_txerr", txerr_a, 0);
    chk("rst_dat", dat_a, 0);
    chk("rst_lvl", lvl_a, 0);
    chk("rst_rdy", ia.rdy_o, 1);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_unf", unf_a, 0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // in-order MII frame from the vector table
    for (int i = 0; i < 11; i++) begin
      step(tv[i].t, tv[i].e, tv[i].d);
      chk($sformatf("frm_txen[%0d]", i), txen_a, tv[i].xt);
      chk($sformatf("frm_txerr[%0d]", i), txerr_a, tv[i].xe);
      chk($sformatf("frm_dat[%0d]", i), dat_a, tv[i].xd);
      chk($sformatf("frm_lvl[%0d]", i), lvl_a, tv[i].xl);
      chk($sformatf("frm_rdy[%0d]", i), ia.rdy_o, 1);
    end
    n = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (!txen_a) n++;
    end
    chk("frm_gap_low", n, 24);

    // RMII dibit order
    do_reset();
    step(1'b1, 1'b1, 8'h1B);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (txen_b) hi++;
      if (i < 4) chk($sformatf("rmii_dat[%0d]", i), dat_b, rm[i]);
    end
    chk("rmii_high", hi, 4);

    // underrun on the RMII instance
    do_reset();
    step(1'b1, 1'b0, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (i < 4) begin
        chk($sformatf("unf_dat[%0d]", i), dat_b, ur[i]);
        chk($sformatf("unf_txen[%0d]", i), txen_b, 1);
        chk($sformatf("unf_txerr[%0d]", i), txerr_b, 0);
      end else begin
        chk($sformatf("unf_er_txen[%0d]", i), txen_b, 1);
        chk($sformatf("unf_er_txerr[%0d]", i), txerr_b, 1);
        chk($sformatf("unf_er_dat[%0d]", i), dat_b, 0);
      end
    end
    chk("unf_flag", unf_b, 1);
    step(1'b1, 1'b1, 8'h00);
    chk("unf_hold_txerr", txerr_b, 1);
    chk("unf_hold_lvl", lvl_b, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("unf_end_txen", txen_b, 0);
    chk("unf_end_txerr", txerr_b, 0);
    chk("unf_end_lvl", lvl_b, 0);
    chk("unf_sticky", unf_b, 1);

    // overflow while the MII instance sits in the gap
    do_reset();
    step(1'b1, 1'b1, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
    chk("ovf_lvl_full", lvl_a, 4);
    chk("ovf_rdy_low", ia.rdy_o, 0);
    chk("ovf_not_yet", ovf_a, 0);
    step(1'b1, 1'b0, 8'h14);
    chk("ovf_lvl_hold", lvl_a, 4);
    chk("ovf_set", ovf_a, 1);
    chk("ovf_in_gap", txen_a, 0);
    err_clr = 1'b1;
    step(1'b1, 1'b0, 8'h15);
    chk("ovf_set_wins", ovf_a, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_cleared", ovf_a, 0);
    err_clr = 1'b0;

    // back-to-back frames with the second one already queued
    do_reset();
    step(1'b1, 1'b1, 8'h21);
    step(1'b1, 1'b0, 8'h43);
    chk("b2b_f1_dat0", dat_a, 4'h1);
    step(1'b1, 1'b1, 8'h65);
    chk("b2b_f1_dat1", dat_a, 4'h2);
    step(1'b0, 1'b0, 8'h00);
    chk("b2b_fall", txen_a, 0);
    n = 0;
    while (!txen_a && n < 60) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("b2b_rise_dist", n, 25);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) chk($sformatf("b2b_f2_dat[%0d]", i), dat_a, b2[i]);
      if (txen_a) hi++;
      step(1'b0, 1'b0, 8'h00);
    end
    chk("b2b_f2_high", hi, 4);

    // asynchronous reset in the middle of a frame
    do_reset();
    step(1'b1, 1'b0, 8'h31);
    step(1'b1, 1'b0, 8'h42);
    step(1'b1, 1'b1, 8'h53);
    chk("mid_sending", txen_a, 1);
    txen = 1'b0;
    eof = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("mid_txen", txen_a, 0);
    chk("mid_dat", dat_a, 0);
    chk("mid_lvl", lvl_a, 0);
    chk("mid_rdy", ia.rdy_o, 1);
    chk("mid_ovf", ovf_a, 0);
    chk("mid_unf", unf_a, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 8'h9C);
    step(1'b0, 1'b0, 8'h00);
    chk("post_dat0", dat_a, 4'hC);
    chk("post_txen0", txen_a, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("post_dat1", dat_a, 4'h9);
    step(1'b0, 1'b0, 8'h00);
    chk("post_txen_end", txen_a, 0);
    chk("post_lvl", lvl_a, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mii_tx_fifo_ser.md
Name: mii_tx_fifo_ser

Overview:
- Single-clock transmit serializer for the Ethernet controller's MII/RMII path.
- Byte stream from the frame transmitter → circular FIFO (parametrised depth) → serialized LS-first into OW-bit symbols on every txclk_i edge.
- Adds frame delimiting (eof tag), start threshold, underrun signalling via TX_ER, overflow drop, inter-frame gap enforcement, and sticky status with clear.

Parameters:
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 bytes (legal 2..6).
- OW, 4, output symbol width; 4 = MII nibble, 2 = RMII dibit; only 4 or 2 legal.
- START_TH, 2, bytes buffered before a frame starts (1..DEPTH); also starts early if any eof byte is queued.
- IFG_CYC, 24, idle output cycles forced after each frame (24 nibbles = 96 bit times).

Ports:
- txclk_i  in  1  symbol clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- txen_i  in  1  input byte valid.
- eof_i  in  1  with txen_i: marks the last byte of a frame.
- dat_i  in  8  input byte.
- rdy_o  out  1  FIFO can accept a byte.
- dat_o  out  OW  output symbol.
- txen_o  out  1  output symbol valid (TX_EN).
- txerr_o  out  1  output error (TX_ER).
- ovf_o  out  1  sticky: overflow occurred.
- unf_o  out  1  sticky: underrun occurred.
- err_clr_i  in  1  clears ovf_o and unf_o.
- lvl_o  out  DEPTH_LOG2+1  FIFO occupancy in bytes.

Behaviour:
- Reset: asynchronous and immediate, also mid-frame.
  - Pointers, lvl_o, eof count, symbol index: 0.
  - State: IDLE.
  - dat_o, txen_o, txerr_o, ovf_o, unf_o: 0.
  - rdy_o: 1 after reset.
- Write side:
  - rdy_o = (lvl_o != DEPTH), combinational from registered lvl_o; no same-cycle pop bypass.
  - txen_i & rdy_o at an edge stores {eof_i, dat_i} at waddr; waddr wraps modulo DEPTH.
  - txen_i & ~rdy_o: byte dropped, pointer unchanged, ovf_o set.
  - Writes are accepted in every state.
- Read side: state machine IDLE / SEND / UNDER / GAP; outputs are registered.
  - IDLE:
    - Drives txen_o=0, txerr_o=0, dat_o=0.
    - Goes to SEND when lvl_o >= START_TH or queued eof count > 0.
    - On that same edge dat_o <= head byte bits [OW-1:0], txen_o <= 1.
  - SEND:
    - Each edge outputs the next OW-bit slice, LS first; 8/OW slices per byte.
    - The head byte is popped on the edge that outputs its last slice.
    - After the last slice of an eof byte: txen_o <= 0, GAP counter loaded, go to GAP.
    - After the last slice of a non-eof byte with FIFO empty: go to UNDER and set unf_o.
      - txen_o=1, txerr_o=1, dat_o=0 from the next edge.
  - UNDER:
    - Holds txen_o=1, txerr_o=1, dat_o=0.
    - Pops and discards one byte per edge while FIFO is non-empty.
    - Popping an eof byte → txen_o, txerr_o <= 0; go to GAP.
  - GAP:
    - txen_o=0 for exactly IFG_CYC edges, then IDLE.
    - The IDLE start check runs on the following edge.
- Latency:
  - Empty FIFO, START_TH=1, byte written at edge k: SEND entered at edge k+1; first slice valid after edge k+1.
  - A frame of N bytes holds txen_o high for exactly N*8/OW cycles.
- Occupancy and pointers:
  - lvl_o counts writes minus pops; simultaneous write and pop leaves lvl_o unchanged.
  - The eof count is tracked identically.
- Sticky flags: set-wins; err_clr_i on the same edge as a new event leaves the flag set.
- Widths: pointers DEPTH_LOG2 bits with natural wrap; lvl_o DEPTH_LOG2+1 bits, never exceeds DEPTH.

Test Plan:
- Frame in order: OW=4, START_TH=2, write 0x55,0xD5,0x12,0xAB(eof) back-to-back → dat_o 5,5,5,D,2,1,B,A; txen_o high exactly 8 cycles; txerr_o 0; then txen_o low 24 cycles.
- RMII order: OW=2, single byte 0x1B with eof → dat_o 3,2,1,0; txen_o high 4 cycles.
- Underrun: START_TH=1, write 0xA5, idle 6 cycles, then write 0x00(eof) → A5 slices sent, then txerr_o=1, txen_o=1, dat_o=0 until 0x00 is discarded; unf_o=1; then gap.
- Overflow: DEPTH=4, hold output in GAP, write 5 bytes → rdy_o=0 at lvl_o=4; 5th byte dropped; ovf_o=1; err_clr_i pulse → ovf_o=0.
- Back-to-back frames, second frame already queued → second frame's txen_o rises exactly IFG_CYC+1 cycles after the first falls.
- Reset mid-frame: assert rst during SEND → txen_o, lvl_o, flags 0 without waiting for a clock edge; next frame transmits correctly from waddr=raddr=0.
